// File: rtl/conv_pkg.sv
// Shared definitions for the pixel unpacker: FSM encoding, default frame size
// and a width helper that never returns zero.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } conv_state_e;

  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_pixel_unpacker_if.sv
// Upstream FIFO read port and downstream pixel stream of the unpacker.
// master = unpacker side, slave = FIFO/sink side.
interface conv_pixel_unpacker_if;
  logic [31:0] fifo_rd_data;
  logic        fifo_rd_vld;
  logic        fifo_rd_en;
  logic [7:0]  pix_data;
  logic        pix_vld;
  logic        pix_rdy;
  logic        pix_sol;
  logic        pix_eol;
  logic        pix_sof;
  logic        pix_eof;

  modport master (
    input  fifo_rd_data, fifo_rd_vld, pix_rdy,
    output fifo_rd_en, pix_data, pix_vld, pix_sol, pix_eol, pix_sof, pix_eof
  );

  modport slave (
    output fifo_rd_data, fifo_rd_vld, pix_rdy,
    input  fifo_rd_en, pix_data, pix_vld, pix_sol, pix_eol, pix_sof, pix_eof
  );
endinterface

// File: rtl/conv_pixel_unpacker.sv
// Unpacks 32-bit FIFO words into an 8-bit pixel stream (LSB byte first) with
// row/frame markers, one frame per start request.
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | popping words and emitting pixels
// DONE    | one-cycle done pulse, start ignored
module conv_pixel_unpacker
  import conv_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  conv_pixel_unpacker_if.master  bus
);

  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NWORDS = NPIX / 4;
  localparam int COL_W  = clog2_min1(IMG_W);
  localparam int ROW_W  = clog2_min1(IMG_H);
  localparam int WRD_W  = clog2_min1(NWORDS + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [WRD_W-1:0] WRD_MAX  = WRD_W'(NWORDS);

  conv_state_e      r_state;
  logic [31:0]      r_buf;
  logic             r_buf_vld;
  logic [1:0]       r_byte_idx;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [WRD_W-1:0] r_words;
  logic             r_busy;
  logic             r_done;

  logic w_xfer;
  logic w_last_byte;
  logic w_col_last;
  logic w_row_last;
  logic w_last_pix;
  logic w_pop;

  assign w_xfer      = r_buf_vld & bus.pix_rdy;
  assign w_last_byte = (r_byte_idx == 2'd3);
  assign w_col_last  = (r_col == COL_LAST);
  assign w_row_last  = (r_row == ROW_LAST);
  assign w_last_pix  = w_col_last & w_row_last;

  // Refill on empty, or in the same cycle the last held byte leaves, so word
  // boundaries cost no bubble. Gated by rst_n so a reset cycle never pops.
  assign w_pop = rst_n & (r_state == ST_RUN) & bus.fifo_rd_vld & (r_words < WRD_MAX)
               & (~r_buf_vld | (w_xfer & w_last_byte));

  assign bus.fifo_rd_en = w_pop;
  assign bus.pix_data   = r_buf[{r_byte_idx, 3'b000} +: 8];
  assign bus.pix_vld    = r_buf_vld;
  assign bus.pix_sol    = r_buf_vld & (r_col == '0);
  assign bus.pix_eol    = r_buf_vld & w_col_last;
  assign bus.pix_sof    = r_buf_vld & (r_col == '0) & (r_row == '0);
  assign bus.pix_eof    = r_buf_vld & w_last_pix;
  assign busy           = r_busy;
  assign done           = r_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_buf      <= '0;
      r_buf_vld  <= 1'b0;
      r_byte_idx <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_words    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_RUN;
            r_busy     <= 1'b1;
            r_buf      <= '0;
            r_buf_vld  <= 1'b0;
            r_byte_idx <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_words    <= '0;
          end
        end
        ST_RUN: begin
          if (w_xfer) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            if (w_last_byte) r_buf_vld <= 1'b0;
            if (w_col_last) begin
              r_col <= '0;
              r_row <= r_row + ROW_W'(1);
            end else begin
              r_col <= r_col + COL_W'(1);
            end
            // Row is cleared on the final pixel so it never wraps past IMG_H-1.
            if (w_last_pix) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_row   <= '0;
            end
          end
          if (w_pop) begin
            r_buf      <= bus.fifo_rd_data;
            r_buf_vld  <= 1'b1;
            r_byte_idx <= '0;
            r_words    <= r_words + WRD_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_pixel_unpacker.sv
// Directed bench for conv_pixel_unpacker (8x2 frame) with a FIFO model and a
// pixel scoreboard filled when words are loaded.
module tb_conv_pixel_unpacker;
  localparam int W = 8;
  localparam int H = 2;
  localparam int NPIX = W * H;

  typedef struct packed {
    logic [7:0] d;
    logic sol, eol, sof, eof;
  } pix_t;

  logic clk;
  logic rst_n;
  logic start;
  logic busy;
  logic done;

  conv_pixel_unpacker_if bus ();

  conv_pixel_unpacker #(.IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops = 0;
  int xfers = 0;
  int done_cnt = 0;
  int gap_cnt = 0;
  int last_pop_cyc = -10;
  int last_xfer_cyc = 0;
  int frame_first_cyc = 0;
  logic [31:0] fifo_q[$];
  pix_t exp_q[$];
  logic gate = 1'b1;
  logic pop_req = 1'b0;
  logic prev_vld = 1'b0;
  logic stalled = 1'b0;
  logic [11:0] held;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FIFO model: pops what the DUT requested at the previous edge, then presents the head.
  always begin
    @(posedge clk);
    #2;
    if (pop_req) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pops++;
    end
    bus.fifo_rd_vld  = gate && (fifo_q.size() > 0);
    bus.fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
  end

  always @(negedge clk) begin
    pix_t e;
    pop_req = bus.fifo_rd_en;
    if (bus.fifo_rd_en) begin
      check("rd_en_without_vld", {31'd0, bus.fifo_rd_vld}, 32'd1);
      last_pop_cyc = cyc;
    end
    if (bus.pix_vld && !prev_vld) check("pop_to_pix_latency", cyc, last_pop_cyc + 1);
    if (stalled) begin
      check("stall_vld", {31'd0, bus.pix_vld}, 32'd1);
      check("stall_hold", {20'd0, bus.pix_data, bus.pix_sol, bus.pix_eol, bus.pix_sof, bus.pix_eof},
            {20'd0, held});
    end
    if (busy && !bus.pix_vld) gap_cnt++;
    if (bus.pix_vld && bus.pix_rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pix", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("pix_data", {24'd0, bus.pix_data}, {24'd0, e.d});
        check("pix_flags", {28'd0, bus.pix_sol, bus.pix_eol, bus.pix_sof, bus.pix_eof},
              {28'd0, e.sol, e.eol, e.sof, e.eof});
        if (e.sof) frame_first_cyc = cyc;
      end
      xfers++;
      last_xfer_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      check("done_latency", cyc, last_xfer_cyc + 1);
    end
    stalled  = bus.pix_vld && !bus.pix_rdy;
    held     = {bus.pix_data, bus.pix_sol, bus.pix_eol, bus.pix_sof, bus.pix_eof};
    prev_vld = bus.pix_vld;
  end

  // Loads n_words into the FIFO; the first n_frame words are expected as a frame.
  task automatic load_words(input int n_words, input int n_frame);
    for (int w = 0; w < n_words; w++) begin
      logic [31:0] word;
      word = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
      fifo_q.push_back(word);
      if (w < n_frame) begin
        for (int b = 0; b < 4; b++) begin
          pix_t e;
          int p, col, row;
          p = 4*w + b;
          col = p % W;
          row = p / W;
          e.d = 8'(p);
          e.sol = (col == 0);
          e.eol = (col == W-1);
          e.sof = (p == 0);
          e.eof = (p == NPIX-1);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input int budget, input bit toggle);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      if (toggle) bus.pix_rdy = ~bus.pix_rdy;
      tick();
      n++;
    end
    check("done_timeout", {31'd0, done_cnt != d0}, 32'd1);
    bus.pix_rdy = 1'b1;
  endtask

  task automatic wait_xfers(input int target, input int budget);
    int n;
    n = 0;
    while (xfers < target && n < budget) begin
      tick();
      n++;
    end
    check("xfer_timeout", {31'd0, xfers >= target}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_vld"}, {31'd0, bus.pix_vld}, 32'd0);
    check({tag, "_data"}, {24'd0, bus.pix_data}, 32'd0);
    check({tag, "_flags"}, {28'd0, bus.pix_sol, bus.pix_eol, bus.pix_sof, bus.pix_eof}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_rd_en"}, {31'd0, bus.fifo_rd_en}, 32'd0);
  endtask

  initial begin
    int p0, x0, g0, d0, n;
    rst_n = 1'b0;
    start = 1'b0;
    bus.pix_rdy = 1'b0;
    gate = 1'b1;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Frame at full rate
    bus.pix_rdy = 1'b1;
    load_words(4, 4);
    tick();
    p0 = pops; x0 = xfers; g0 = gap_cnt;
    pulse_start();
    wait_done(200, 1'b0);
    tick();
    check("t1_pops", pops - p0, 4);
    check("t1_xfers", xfers - x0, 16);
    check("t1_span", last_xfer_cyc - frame_first_cyc, 15);
    check("t1_gaps", gap_cnt - g0, 2);
    check("t1_busy_idle", {31'd0, busy}, 32'd0);
    check("t1_scoreboard_empty", exp_q.size(), 0);

    // Downstream ready toggling
    load_words(4, 4);
    tick();
    p0 = pops; x0 = xfers;
    pulse_start();
    wait_done(300, 1'b1);
    tick();
    check("t2_pops", pops - p0, 4);
    check("t2_xfers", xfers - x0, 16);
    check("t2_scoreboard_empty", exp_q.size(), 0);

    // FIFO runs dry after the first word
    load_words(4, 4);
    tick();
    p0 = pops; g0 = gap_cnt;
    pulse_start();
    n = 0;
    while (pops - p0 < 1 && n < 50) begin tick(); n++; end
    check("t3_first_pop", {31'd0, (pops - p0) >= 1}, 32'd1);
    gate = 1'b0;
    repeat (5) tick();
    gate = 1'b1;
    wait_done(200, 1'b0);
    tick();
    check("t3_pops", pops - p0, 4);
    check("t3_gap_seen", {31'd0, (gap_cnt - g0) >= 4}, 32'd1);
    check("t3_scoreboard_empty", exp_q.size(), 0);

    // Surplus words stay in the FIFO
    load_words(6, 4);
    tick();
    p0 = pops;
    pulse_start();
    wait_done(200, 1'b0);
    repeat (4) tick();
    check("t4_pops", pops - p0, 4);
    check("t4_fifo_left", fifo_q.size(), 2);
    check("t4_scoreboard_empty", exp_q.size(), 0);
    fifo_q.delete();
    tick();

    // Reset mid-frame
    load_words(4, 4);
    tick();
    x0 = xfers;
    pulse_start();
    wait_xfers(x0 + 5, 100);
    rst_n = 1'b0;
    tick();
    check_idle_outputs("midreset");
    rst_n = 1'b1;
    p0 = pops;
    repeat (3) tick();
    check("t5_no_pops_after_reset", pops - p0, 0);
    fifo_q.delete();
    exp_q.delete();
    tick();

    // Fresh frame with start pulsed during RUN
    load_words(4, 4);
    tick();
    p0 = pops; x0 = xfers; d0 = done_cnt;
    pulse_start();
    wait_xfers(x0 + 6, 100);
    pulse_start();
    wait_done(200, 1'b0);
    repeat (4) tick();
    check("t6_pops", pops - p0, 4);
    check("t6_xfers", xfers - x0, 16);
    check("t6_single_done", done_cnt - d0, 1);
    check("t6_busy_idle", {31'd0, busy}, 32'd0);
    check("t6_scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/conv_pixel_unpacker.md
CONV_PIXEL_UNPACKER -- requirements
Module: conv_pixel_unpacker

Interface
REQ-001 Parameter IMG_W, default 28, frame width in 8-bit pixels; SHALL be a multiple of 4.
REQ-002 Parameter IMG_H, default 28, frame height in rows.
REQ-003 clk  input  1  single clock; all logic SHALL be synchronous to its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to unpack one frame; sampled only in IDLE.
REQ-006 fifo_rd_data  input  32  show-ahead word from the upstream 64-in/32-out prefetch FIFO; valid whenever fifo_rd_vld=1.
REQ-007 fifo_rd_vld  input  1  upstream word available.
REQ-008 fifo_rd_en  output  1  pop strobe to upstream FIFO.
REQ-009 pix_data  output  8  pixel value.
REQ-010 pix_vld  output  1  pixel valid.
REQ-011 pix_rdy  input  1  downstream ready; pixel transfers when pix_vld & pix_rdy.
REQ-012 pix_sol / pix_eol  output  1 each  first / last pixel of a row, qualified by pix_vld.
REQ-013 pix_sof / pix_eof  output  1 each  first / last pixel of the frame, qualified by pix_vld.
REQ-014 busy  output  1  high in RUN and DONE.
REQ-015 done  output  1  one-cycle pulse after the last frame pixel transfers.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on transfer of pixel IMG_W*IMG_H-1; DONE->IDLE unconditionally after one cycle.
REQ-017 Entering RUN SHALL clear the word, byte, column and row counters and the holding register.
REQ-018 The block SHALL hold one 32-bit word plus a valid flag and a 2-bit byte index; bytes SHALL be emitted in order [7:0], [15:8], [23:16], [31:24].
REQ-019 fifo_rd_en SHALL equal RUN & fifo_rd_vld & (words_read < IMG_W*IMG_H/4) & (~buf_vld | (pix_vld & pix_rdy & byte_idx==3)); it SHALL be combinational and never asserted when fifo_rd_vld=0.
REQ-020 Latency: word popped at cycle n SHALL present byte 0 with pix_vld=1 at cycle n+1.
REQ-021 With fifo_rd_vld and pix_rdy held high, throughput SHALL be one pixel per cycle with no bubble at word boundaries.
REQ-022 pix_data and flags SHALL remain stable while pix_vld=1 and pix_rdy=0.
REQ-023 Column counter SHALL count 0..IMG_W-1 per transfer and wrap to 0, incrementing row 0..IMG_H-1; pix_sol=(col==0), pix_eol=(col==IMG_W-1), pix_sof=(col==0&row==0), pix_eof=(col==IMG_W-1&row==IMG_H-1).
REQ-024 The block SHALL pop exactly IMG_W*IMG_H/4 words per frame; words beyond that SHALL remain in the FIFO.
REQ-025 FIFO empty mid-frame SHALL deassert pix_vld after the held word drains, with counters preserved; output resumes when fifo_rd_vld returns.
REQ-026 start while busy SHALL be ignored; start in the same cycle as DONE SHALL be ignored.
REQ-027 Counter widths SHALL be $clog2 of their maximum+1; no arithmetic overflow within a frame.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE, clear all counters, buf_vld=0, and outputs fifo_rd_en=0, pix_vld=0, pix_data=0, all flags=0, busy=0, done=0.
REQ-029 Reset mid-frame SHALL abandon the frame without further pops; upstream FIFO contents are not flushed by this block.

Structure
REQ-030 The FSM state encoding and default IMG_W/IMG_H constants SHALL live in shared package conv_pkg.
REQ-031 The block SHALL be a single module; no sub-module is warranted.

Verification
REQ-032 IMG_W=8, IMG_H=2, FIFO preloaded with 4 words 0x03020100..0x0F0E0D0C, pix_rdy=1, start -> pixels 0x00..0x0F on consecutive cycles, sof on 0x00, eol on 0x07 and 0x0F, eof+sol pattern correct, done one cycle after 0x0F.
REQ-033 Same frame with pix_rdy toggling 1,0,1,0 -> each pixel held stable while stalled, 16 transfers, exactly 4 pops.
REQ-034 fifo_rd_vld low for 5 cycles after word 1 -> pix_vld drops after byte 3, resumes with 0x04, counters continuous.
REQ-035 FIFO holds 6 words, frame needs 4 -> exactly 4 fifo_rd_en pulses, 2 words remain.
REQ-036 rst_n=0 at pixel 5 -> next cycle all outputs zero, IDLE; new start -> fresh frame with sof on first pixel.
REQ-037 start pulsed during RUN -> ignored, no counter disturbance, single done pulse.
